// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types, constants and helpers for the AES-128 key-schedule sequencer.
//   aes_128 / aes_word / ByteType : 128-bit block, 32-bit word, byte
//   AES_NR                        : number of expansion rounds for AES-128
//   RCON_INIT                     : rcon value used by expansion round 1
//   xtime()                       : multiply-by-x in GF(2^8), rcon stepping
//   ctrl_state_e                  : sequencer states; ST_REPLAY exists only
//                                   when AES_KEY_CACHE_EN is defined
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef logic [127:0] aes_128;
  typedef logic [31:0]  aes_word;
  typedef logic [7:0]   ByteType;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EMIT,
    ST_SREQ,
    ST_SWAIT,
    ST_EXPAND,
    ST_DONE
`ifdef AES_KEY_CACHE_EN
    , ST_REPLAY
`endif
  } ctrl_state_e;

  // Reduction polynomial x^8+x^4+x^3+x+1 folds the carry back as 8'h1b.
  function automatic ByteType xtime(input ByteType b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rk_cache.sv
// ---------------------------------------------------------------------------
// aes_rk_cache
// Round-key store used by the AES_KEY_CACHE_EN build of aes_key_sched_ctrl.
// One write port and one combinational read port.
//   clk   : clock
//   we    : write enable
//   waddr : round index to write
//   wdata : round key to store
//   raddr : round index to read
//   rdata : stored round key at raddr
// ---------------------------------------------------------------------------
module aes_rk_cache
  import aes_pkg::*;
#(
  parameter int DEPTH = AES_NR + 1,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [127:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [127:0]  rdata
);

  aes_128 mem_q [DEPTH];

  // NOTE: the storage array has no reset; a separate valid bit in the
  // controller guards every read, so clearing it would only cost flops.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_sched_ctrl
// Sequencer for the AES-128 round-key generator (aes_key_gen). Loads a key,
// walks the generator through NR expansion rounds, routes each SubWord
// through a shared, arbitrated S-box port and streams round keys 0..NR out
// on a valid/ready handshake.
//
// Ports:
//   clk, nrst             : clock, synchronous active-high reset
//   start, key_in         : begin expansion with key_in (accepted in IDLE)
//   kg_*                  : control/data to and from aes_key_gen
//   sbox_req/gnt/word     : shared S-box request, grant, word presented
//   sbox_res/vld          : S-box result and its valid strobe
//   rk_valid/ready/rnd/data : round-key stream to the cipher datapath
//   busy, done, err       : status; done and err are one-cycle pulses
//   replay                : stream cached keys (AES_KEY_CACHE_EN only)
//
// Optional build macro AES_KEY_CACHE_EN adds an (NR+1)-entry round-key store
// and a REPLAY state; without it replay is ignored.
// ---------------------------------------------------------------------------
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NR           = AES_NR,
  parameter int SBOX_TIMEOUT = 16,
  parameter int RND_W        = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [127:0]     key_in,
  output logic             kg_en,
  output logic             kg_gen_key,
  output logic             kg_next_rnd,
  output logic [RND_W-1:0] kg_rnd_number,
  output logic [7:0]       kg_rcon,
  output logic [127:0]     kg_key,
  output logic [31:0]      kg_sub_i,
  input  logic [31:0]      kg_sub_o,
  input  logic [127:0]     kg_key_o,
  output logic             sbox_req,
  input  logic             sbox_gnt,
  output logic [31:0]      sbox_word,
  input  logic [31:0]      sbox_res,
  input  logic             sbox_vld,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [RND_W-1:0] rk_rnd,
  output logic [127:0]     rk_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             replay
);

  localparam int TO_W = $clog2(SBOX_TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(SBOX_TIMEOUT - 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(NR);

  ctrl_state_e      state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic             kg_en_q, kg_en_d, kg_gen_key_q, kg_gen_key_d;
  logic             kg_next_rnd_q, kg_next_rnd_d;
  logic [RND_W-1:0] rnd_q, rnd_d, rk_rnd_q, rk_rnd_d;
  ByteType          rcon_q, rcon_d;
  aes_128           kg_key_q, kg_key_d;
  aes_word          kg_sub_i_q, kg_sub_i_d, sbox_word_q, sbox_word_d;
  logic             sbox_req_q, sbox_req_d, rk_valid_q, rk_valid_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             rk_accept, sbox_abort;
  aes_128           rk_data_mux;

`ifdef AES_KEY_CACHE_EN
  logic   cache_vld_q, cache_vld_d;
  aes_128 cache_rdata;

  aes_rk_cache #(.DEPTH(NR + 1), .AW(RND_W)) u_rk_cache (
    .clk   (clk),
    .we    ((state_q == ST_EMIT) && rk_accept),
    .waddr (rk_rnd_q),
    .wdata (rk_data_mux),
    .raddr (rk_rnd_q),
    .rdata (cache_rdata)
  );
`else
  logic unused_replay;
  assign unused_replay = replay;
`endif

  assign rk_accept = rk_valid_q & rk_ready;

  // Round 0 is the cipher key itself; later rounds come straight from the
  // generator, which only moves on an EXPAND strobe, so the value is stable
  // for the whole EMIT handshake.
  always_comb begin
    rk_data_mux = '0;
    if (rk_valid_q) begin
      if (rk_rnd_q == '0) rk_data_mux = kg_key_q;
      else                rk_data_mux = kg_key_o;
`ifdef AES_KEY_CACHE_EN
      if (state_q == ST_REPLAY) rk_data_mux = cache_rdata;
`endif
    end
  end

  // NOTE: every _d gets its hold value first so no path through the case
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    kg_en_d       = 1'b0;
    kg_gen_key_d  = 1'b0;
    kg_next_rnd_d = 1'b0;
    rnd_d         = rnd_q;
    rcon_d        = rcon_q;
    kg_key_d      = kg_key_q;
    kg_sub_i_d    = kg_sub_i_q;
    sbox_req_d    = sbox_req_q;
    sbox_word_d   = sbox_word_q;
    rk_valid_d    = rk_valid_q;
    rk_rnd_d      = rk_rnd_q;
    to_cnt_d      = to_cnt_q;
    sbox_abort    = 1'b0;
`ifdef AES_KEY_CACHE_EN
    cache_vld_d   = cache_vld_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_LOAD;
          kg_key_d     = key_in;
          busy_d       = 1'b1;
          kg_en_d      = 1'b1;
          kg_gen_key_d = 1'b1;
          rnd_d        = '0;
          rcon_d       = RCON_INIT;
`ifdef AES_KEY_CACHE_EN
          cache_vld_d  = 1'b0;
        end else if (replay && cache_vld_q) begin
          state_d    = ST_REPLAY;
          busy_d     = 1'b1;
          rk_valid_d = 1'b1;
          rk_rnd_d   = '0;
`endif
        end
      end
      ST_LOAD: begin
        state_d    = ST_EMIT;
        rk_valid_d = 1'b1;
        rk_rnd_d   = '0;
      end
      ST_EMIT: begin
        if (rk_accept) begin
          rk_valid_d = 1'b0;
          if (rk_rnd_q == RND_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = ST_SREQ;
            sbox_req_d  = 1'b1;
            sbox_word_d = kg_sub_o;
            to_cnt_d    = '0;
          end
        end
      end
      ST_SREQ: begin
        if (sbox_gnt) begin
          state_d  = ST_SWAIT;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          sbox_abort = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_SWAIT: begin
        if (sbox_vld) begin
          state_d       = ST_EXPAND;
          sbox_req_d    = 1'b0;
          kg_sub_i_d    = sbox_res;
          kg_en_d       = 1'b1;
          kg_next_rnd_d = 1'b1;
          rnd_d         = rnd_q + RND_W'(1);
        end else if (to_cnt_q == TO_LAST) begin
          sbox_abort = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_EXPAND: begin
        // rcon_q was presented during this round; step it for the next one.
        state_d    = ST_EMIT;
        rk_valid_d = 1'b1;
        rk_rnd_d   = rnd_q;
        rcon_d     = xtime(rcon_q);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
`ifdef AES_KEY_CACHE_EN
        cache_vld_d = 1'b1;
`endif
      end
`ifdef AES_KEY_CACHE_EN
      ST_REPLAY: begin
        if (rk_accept) begin
          if (rk_rnd_q == RND_LAST) begin
            state_d    = ST_DONE;
            rk_valid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            rk_rnd_d = rk_rnd_q + RND_W'(1);
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (sbox_abort) begin
      state_d    = ST_IDLE;
      sbox_req_d = 1'b0;
      busy_d     = 1'b0;
      err_d      = 1'b1;
      to_cnt_d   = '0;
`ifdef AES_KEY_CACHE_EN
      cache_vld_d = 1'b0;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      kg_en_q       <= 1'b0;
      kg_gen_key_q  <= 1'b0;
      kg_next_rnd_q <= 1'b0;
      rnd_q         <= '0;
      rcon_q        <= RCON_INIT;
      kg_key_q      <= '0;
      kg_sub_i_q    <= '0;
      sbox_req_q    <= 1'b0;
      sbox_word_q   <= '0;
      rk_valid_q    <= 1'b0;
      rk_rnd_q      <= '0;
      to_cnt_q      <= '0;
`ifdef AES_KEY_CACHE_EN
      cache_vld_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      kg_en_q       <= kg_en_d;
      kg_gen_key_q  <= kg_gen_key_d;
      kg_next_rnd_q <= kg_next_rnd_d;
      rnd_q         <= rnd_d;
      rcon_q        <= rcon_d;
      kg_key_q      <= kg_key_d;
      kg_sub_i_q    <= kg_sub_i_d;
      sbox_req_q    <= sbox_req_d;
      sbox_word_q   <= sbox_word_d;
      rk_valid_q    <= rk_valid_d;
      rk_rnd_q      <= rk_rnd_d;
      to_cnt_q      <= to_cnt_d;
`ifdef AES_KEY_CACHE_EN
      cache_vld_q   <= cache_vld_d;
`endif
    end
  end

  assign kg_en         = kg_en_q;
  assign kg_gen_key    = kg_gen_key_q;
  assign kg_next_rnd   = kg_next_rnd_q;
  assign kg_rnd_number = rnd_q;
  assign kg_rcon       = rcon_q;
  assign kg_key        = kg_key_q;
  assign kg_sub_i      = kg_sub_i_q;
  assign sbox_req      = sbox_req_q;
  assign sbox_word     = sbox_word_q;
  assign rk_valid      = rk_valid_q;
  assign rk_rnd        = rk_rnd_q;
  assign rk_data       = rk_data_mux;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_key_sched_ctrl
// Self-checking bench for aes_key_sched_ctrl. Surrounds the DUT with a
// behavioural aes_key_gen, an S-box responder with programmable grant delay
// and a round-key sink with programmable back-pressure. Expected round keys
// come from an independent FIPS-197 key expansion and are queued when a
// run is started, then popped as the sink accepts keys.
// ---------------------------------------------------------------------------
module tb_aes_key_sched_ctrl;

  localparam int STALL_CYCLES = 7;
  localparam int BUDGET       = 600;

  logic         clk = 1'b0;
  logic         nrst, start, replay;
  logic [127:0] key_in;
  logic         kg_en, kg_gen_key, kg_next_rnd;
  logic [3:0]   kg_rnd_number;
  logic [7:0]   kg_rcon;
  logic [127:0] kg_key, kg_key_o;
  logic [31:0]  kg_sub_i, kg_sub_o;
  logic         sbox_req, sbox_gnt, sbox_vld;
  logic [31:0]  sbox_word, sbox_res;
  logic         rk_valid, rk_ready;
  logic [3:0]   rk_rnd;
  logic [127:0] rk_data;
  logic         busy, done, err;

  int errors = 0;
  int checks = 0;

  logic [131:0] exp_q[$];
  logic [127:0] last_key;
  logic [127:0] gen_key = '0;
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  int  gnt_delay  = 0;
  bit  gnt_en     = 1'b1;
  int  stall_rnd  = -1;
  int  stall_left = 0;
  int  done_cnt   = 0;
  bit  sbox_seen  = 1'b0;
  bit  kgen_seen  = 1'b0;

  always #5 clk = ~clk;

  aes_key_sched_ctrl dut (
    .clk(clk), .nrst(nrst), .start(start), .key_in(key_in),
    .kg_en(kg_en), .kg_gen_key(kg_gen_key), .kg_next_rnd(kg_next_rnd),
    .kg_rnd_number(kg_rnd_number), .kg_rcon(kg_rcon), .kg_key(kg_key),
    .kg_sub_i(kg_sub_i), .kg_sub_o(kg_sub_o), .kg_key_o(kg_key_o),
    .sbox_req(sbox_req), .sbox_gnt(sbox_gnt), .sbox_word(sbox_word),
    .sbox_res(sbox_res), .sbox_vld(sbox_vld),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_rnd(rk_rnd), .rk_data(rk_data),
    .busy(busy), .done(done), .err(err), .replay(replay)
  );

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, aa = a, bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v = 8'h00;
    if (x != 8'h00) begin
      v = 8'h01;
      for (int i = 0; i < 254; i++) v = gmul(v, x);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] ref_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/4-1], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- behavioural aes_key_gen ----------------
  always @(posedge clk) begin
    logic [31:0] t, w0, w1, w2, w3;
    if (kg_en && kg_gen_key) gen_key <= kg_key;
    else if (kg_en && kg_next_rnd) begin
      t  = kg_sub_i ^ {kg_rcon, 24'h0};
      w0 = gen_key[127:96] ^ t;
      w1 = gen_key[95:64] ^ w0;
      w2 = gen_key[63:32] ^ w1;
      w3 = gen_key[31:0] ^ w2;
      gen_key <= {w0, w1, w2, w3};
    end
  end
  assign kg_key_o = gen_key;
  assign kg_sub_o = {gen_key[23:0], gen_key[31:24]};

  // ---------------- S-box responder ----------------
  initial begin
    bit granted = 1'b0;
    int req_cnt = 0;
    logic [31:0] word_hold = '0;
    sbox_gnt = 1'b0; sbox_vld = 1'b0; sbox_res = '0;
    forever begin
      @(negedge clk);
      if (!sbox_req) begin
        sbox_gnt = 1'b0; sbox_vld = 1'b0; granted = 1'b0; req_cnt = 0;
      end else if (!granted) begin
        checks++;
        if (req_cnt == 0) begin
          word_hold = sbox_word;
          if (sbox_word !== kg_sub_o) begin
            errors++;
            $display("FAIL sbox_word: got %h want %h", sbox_word, kg_sub_o);
          end
        end else if (sbox_word !== word_hold) begin
          errors++;
          $display("FAIL sbox_word_hold: got %h want %h", sbox_word, word_hold);
        end
        if (gnt_en && req_cnt >= gnt_delay) begin sbox_gnt = 1'b1; granted = 1'b1; end
        else sbox_gnt = 1'b0;
        req_cnt++;
      end else begin
        sbox_gnt = 1'b0; sbox_vld = 1'b1; sbox_res = sub_word(sbox_word);
      end
    end
  end

  // ---------------- round-key sink + scoreboard ----------------
  initial begin
    logic [127:0] hold_data = '0;
    logic [131:0] exp;
    rk_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rk_valid && stall_left > 0 && int'(rk_rnd) == stall_rnd) begin
        rk_ready = 1'b0;
        if (stall_left == STALL_CYCLES) hold_data = rk_data;
        else begin
          checks++;
          if (rk_data !== hold_data) begin
            errors++;
            $display("FAIL rk_data_hold: got %h want %h", rk_data, hold_data);
          end
        end
        stall_left--;
      end else rk_ready = 1'b1;
      if (rk_valid && rk_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rk_unexpected: got rnd %0d %h want none", rk_rnd, rk_data);
        end else begin
          exp = exp_q.pop_front();
          if ({rk_rnd, rk_data} !== exp) begin
            errors++;
            $display("FAIL rk_key: got rnd %0d %h want rnd %0d %h",
                     rk_rnd, rk_data, exp[131:128], exp[127:0]);
          end
        end
        last_key = rk_data;
      end
    end
  end

  // ---------------- observers: rcon per round, activity flags ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (sbox_req) sbox_seen = 1'b1;
      if (kg_en) kgen_seen = 1'b1;
      if (kg_next_rnd) begin
        checks++;
        if (kg_rnd_number < 4'd1 || kg_rnd_number > 4'd10) begin
          errors++;
          $display("FAIL rcon_round: got round %0d want 1..10", kg_rnd_number);
        end else if (kg_rcon !== rcon_tab[int'(kg_rnd_number) - 1]) begin
          errors++;
          $display("FAIL rcon: round %0d got %h want %h", kg_rnd_number, kg_rcon,
                   rcon_tab[int'(kg_rnd_number) - 1]);
        end
      end
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic push_keys(input logic [127:0] key);
    for (int r = 0; r <= 10; r++) exp_q.push_back({4'(r), ref_key(key, r)});
  endtask

  task automatic test_reset();
    nrst = 1'b1; start = 1'b0; replay = 1'b0; key_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, kg_en, kg_gen_key, kg_next_rnd, sbox_req, rk_valid} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {busy, done, err, kg_en, kg_gen_key, kg_next_rnd, sbox_req, rk_valid});
    end
    checks++;
    if ({kg_rnd_number, rk_rnd, kg_key, kg_sub_i, sbox_word, rk_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: got nonzero want 0");
    end
    checks++;
    if (kg_rcon !== 8'h01) begin
      errors++;
      $display("FAIL reset_rcon: got %h want 01", kg_rcon);
    end
    nrst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_expansion(input logic [127:0] key, input int gdelay,
                               input int srnd, input bit poke_busy);
    int d0 = done_cnt;
    bit seen = 1'b0;
    push_keys(key);
    gnt_delay  = gdelay;
    stall_rnd  = srnd;
    stall_left = (srnd >= 0) ? STALL_CYCLES : 0;
    start = 1'b1; key_in = key;
    @(negedge clk);
    start = 1'b0; key_in = '0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b want 1", busy); end
    for (int c = 0; c < BUDGET && !seen; c++) begin
      @(negedge clk);
      if (poke_busy && c == 10) begin start = 1'b1; key_in = ~key; end
      else begin start = 1'b0; key_in = '0; end
      seen = done;
    end
    start = 1'b0;
    checks++;
    if (!seen) begin errors++; $display("FAIL done_timeout: got no done want done"); end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL done_exit: got done,busy=%b want 00", {done, busy});
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++; $display("FAIL done_pulses: got %0d want 1", done_cnt - d0);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL keys_left: got %0d want 0", exp_q.size());
      exp_q.delete();
    end
    stall_rnd = -1; stall_left = 0; gnt_delay = 0;
  endtask

  task automatic test_fips();
    run_expansion(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, -1, 1'b0);
    checks++;
    if (last_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++; $display("FAIL fips_key10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", last_key);
    end
  endtask

  task automatic test_stall();
    run_expansion(128'h2b7e151628aed2a6abf7158809cf4f3c, 5, 3, 1'b1);
    checks++;
    if (last_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++; $display("FAIL stall_key10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", last_key);
    end
  endtask

  task automatic test_timeout();
    int d0 = done_cnt;
    int cyc = 0;
    bit seen = 1'b0;
    exp_q.push_back({4'd0, 128'h000102030405060708090a0b0c0d0e0f});
    gnt_en = 1'b0;
    start = 1'b1; key_in = 128'h000102030405060708090a0b0c0d0e0f;
    @(negedge clk);
    start = 1'b0; key_in = '0;
    for (int c = 0; c < 50 && !seen; c++) begin @(negedge clk); seen = sbox_req; end
    checks++;
    if (!seen) begin errors++; $display("FAIL timeout_req: got no sbox_req want sbox_req"); end
    while (!err && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc !== 16) begin errors++; $display("FAIL timeout_cycles: got %0d want 16", cyc); end
    checks++;
    if ({busy, sbox_req} !== 2'b00) begin
      errors++; $display("FAIL timeout_status: got busy,req=%b want 00", {busy, sbox_req});
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b want 0", err); end
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL timeout_done: got %0d want %0d", done_cnt, d0); end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL timeout_keys: got %0d want 0", exp_q.size()); exp_q.delete();
    end
    gnt_en = 1'b1;
  endtask

  task automatic test_mid_reset();
    int d0 = done_cnt;
    bit seen = 1'b0;
    push_keys(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
    start = 1'b1; key_in = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    @(negedge clk);
    start = 1'b0; key_in = '0;
    for (int c = 0; c < BUDGET && !seen; c++) begin
      @(negedge clk); seen = (kg_rnd_number == 4'd6);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midrst_round6: got %0d want 6", kg_rnd_number); end
    nrst = 1'b1;
    @(negedge clk);
    nrst = 1'b0;
    checks++;
    if ({busy, done, err, kg_en, kg_gen_key, kg_next_rnd, sbox_req, rk_valid} !== 8'h00) begin
      errors++;
      $display("FAIL midrst_ctrl: got %b want 00000000",
               {busy, done, err, kg_en, kg_gen_key, kg_next_rnd, sbox_req, rk_valid});
    end
    checks++;
    if ({kg_rnd_number, rk_rnd, kg_key, kg_sub_i, sbox_word, rk_data} !== '0) begin
      errors++; $display("FAIL midrst_data: got nonzero want 0");
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    checks++;
    if ({done_cnt, busy} !== {d0, 1'b0}) begin
      errors++; $display("FAIL midrst_idle: got done_cnt %0d busy %b want %0d 0", done_cnt, busy, d0);
    end
    run_expansion(128'h00112233445566778899aabbccddeeff, 0, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [127:0] k;
    for (int n = 0; n < 2; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      run_expansion(k, n * 2, -1, 1'b0);
      checks++;
      if (last_key !== ref_key(k, 10)) begin
        errors++; $display("FAIL b2b_key10: got %h want %h", last_key, ref_key(k, 10));
      end
    end
  endtask

  task automatic test_replay();
    logic [127:0] k = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    int d0;
    bit seen = 1'b0;
    run_expansion(k, 0, -1, 1'b0);
    d0 = done_cnt;
    sbox_seen = 1'b0; kgen_seen = 1'b0;
`ifdef AES_KEY_CACHE_EN
    push_keys(k);
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    for (int c = 0; c < BUDGET && !seen; c++) begin @(negedge clk); seen = done; end
    @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL replay_done: got %0d want 1", done_cnt - d0); end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL replay_keys: got %0d want 0", exp_q.size()); exp_q.delete();
    end
`else
    replay = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({busy, rk_valid} !== 2'b00) begin
      errors++; $display("FAIL replay_ignored: got busy,valid=%b want 00", {busy, rk_valid});
    end
    replay = 1'b0;
    @(negedge clk);
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL replay_done: got %0d want %0d", done_cnt, d0); end
`endif
    checks++;
    if ({sbox_seen, kgen_seen} !== 2'b00) begin
      errors++; $display("FAIL replay_quiet: got sbox,kgen=%b want 00", {sbox_seen, kgen_seen});
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_stall();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    test_replay();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
